// File: rtl/out_channel_fifo_if.sv
// Handshake bundle between the executor's out instruction, the output channel FIFO
// and its downstream consumer.
interface out_channel_fifo_if #(
   parameter int MemoryElementWidth = 12
);
   logic                          inValid;
   logic [MemoryElementWidth-1:0] inData;
   logic                          inReady;
   logic                          outValid;
   logic [MemoryElementWidth-1:0] outData;
   logic                          outReady;
   logic [11:0]                   count;
   logic [31:0]                   total;
   logic                          overflow;

   // Environment side: producer and consumer of the FIFO.
   modport master (
      output inValid,
      output inData,
      input  inReady,
      input  outValid,
      input  outData,
      output outReady,
      input  count,
      input  total,
      input  overflow
   );

   // FIFO side.
   modport slave (
      input  inValid,
      input  inData,
      output inReady,
      output outValid,
      output outData,
      input  outReady,
      output count,
      output total,
      output overflow
   );
endinterface

// File: rtl/out_channel_fifo.sv
// First-word-fall-through output channel FIFO: circular buffer of NOut words with
// occupancy, accepted-word total and a sticky overflow flag for dropped pushes.
module out_channel_fifo #(
   parameter int MemoryElementWidth = 12,
   parameter int NOut               = 200
) (
   input logic               clock,
   input logic               reset,
   input logic               clear,
   out_channel_fifo_if.slave bus
);

   localparam int                 PtrW    = (NOut > 2) ? $clog2(NOut) : 1;
   localparam logic [PtrW-1:0]    LastIdx = PtrW'(NOut - 1);
   localparam logic [11:0]        Depth   = 12'(NOut);

   logic [MemoryElementWidth-1:0] r_mem [NOut];
   logic [PtrW-1:0]               r_wr_ptr;
   logic [PtrW-1:0]               r_rd_ptr;
   logic [11:0]                   r_count;
   logic [31:0]                   r_total;
   logic                          r_overflow;

   logic                          w_in_ready;
   logic                          w_out_valid;
   logic                          w_push;
   logic                          w_pop;
   logic                          w_drop;
   logic [PtrW-1:0]               w_wr_ptr_nxt;
   logic [PtrW-1:0]               w_rd_ptr_nxt;
   logic [11:0]                   w_count_nxt;
   logic [31:0]                   w_total_nxt;
   logic                          w_overflow_nxt;
   logic [MemoryElementWidth-1:0] w_out_data;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      if (p == LastIdx) begin
         return {PtrW{1'b0}};
      end else begin
         return p + PtrW'(1);
      end
   endfunction

   // Handshake qualification; a pop never frees space for a push in the same cycle.
   always_comb begin
      w_in_ready  = (r_count < Depth);
      w_out_valid = (r_count != 12'd0);
      w_push      = bus.inValid & w_in_ready;
      w_pop       = w_out_valid & bus.outReady;
      w_drop      = bus.inValid & ~w_in_ready;
   end

   // Next-state computation; clear overrides any push or pop.
   always_comb begin
      w_wr_ptr_nxt   = r_wr_ptr;
      w_rd_ptr_nxt   = r_rd_ptr;
      w_count_nxt    = r_count;
      w_total_nxt    = r_total;
      w_overflow_nxt = r_overflow;
      if (clear) begin
         w_wr_ptr_nxt   = {PtrW{1'b0}};
         w_rd_ptr_nxt   = {PtrW{1'b0}};
         w_count_nxt    = 12'd0;
         w_total_nxt    = 32'd0;
         w_overflow_nxt = 1'b0;
      end else begin
         if (w_push) begin
            w_wr_ptr_nxt = ptr_inc(r_wr_ptr);
            w_total_nxt  = r_total + 32'd1;
         end else begin
            w_wr_ptr_nxt = r_wr_ptr;
            w_total_nxt  = r_total;
         end
         if (w_pop) begin
            w_rd_ptr_nxt = ptr_inc(r_rd_ptr);
         end else begin
            w_rd_ptr_nxt = r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 12'd1;
            2'b01:   w_count_nxt = r_count - 12'd1;
            default: w_count_nxt = r_count;
         endcase
         if (w_drop) begin
            w_overflow_nxt = 1'b1;
         end else begin
            w_overflow_nxt = r_overflow;
         end
      end
   end

   // Control state register with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr   <= {PtrW{1'b0}};
         r_rd_ptr   <= {PtrW{1'b0}};
         r_count    <= 12'd0;
         r_total    <= 32'd0;
         r_overflow <= 1'b0;
      end else begin
         r_wr_ptr   <= w_wr_ptr_nxt;
         r_rd_ptr   <= w_rd_ptr_nxt;
         r_count    <= w_count_nxt;
         r_total    <= w_total_nxt;
         r_overflow <= w_overflow_nxt;
      end
   end

   // Storage is not reset; stale words are masked by the empty check on the read side.
   always_ff @(posedge clock) begin
      if (w_push && !clear) begin
         r_mem[r_wr_ptr] <= bus.inData;
      end
   end

   // Head word falls through combinationally, forced to zero while empty.
   always_comb begin
      if (w_out_valid) begin
         w_out_data = r_mem[r_rd_ptr];
      end else begin
         w_out_data = {MemoryElementWidth{1'b0}};
      end
   end

   assign bus.inReady  = w_in_ready;
   assign bus.outValid = w_out_valid;
   assign bus.outData  = w_out_data;
   assign bus.count    = r_count;
   assign bus.total    = r_total;
   assign bus.overflow = r_overflow;

endmodule
